pmp_csr_bank: RTL and testbench

Machine-mode PMP configuration register bank for the RV64 core. It holds pmpcfg/pmpaddr state and services CSR read/write/set/clear requests from the CSR unit. It enforces WARL and lock rules, and drives the flattened `conf_addr` / `conf` buses consumed directly by the combinational PMP checker. It also emits a one-cycle change pulse so the MMU can flush cached translations.

---
 rtl/pmp_pkg.sv | 47 ++++
 rtl/pmp_cfg_warl.sv | 26 ++
 rtl/pmp_csr_bank.sv | 129 ++++++++++++
 tb/tb_pmp_csr_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// Shared PMP types and constants: address-mode and CSR-op encodings,
// packed pmpcfg byte layout, PMP CSR addresses and the CSR op helper.
package pmp_pkg;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } pmp_amode_e;

  typedef struct packed {
    logic       locked;
    logic [1:0] reserved;
    pmp_amode_e addr_mode;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPCFG2  = 12'h3A2;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
  localparam int          MAX_ENTRIES  = 16;

  // Value a CSR op would leave behind, given the current CSR value.
  function automatic logic [63:0] csr_apply(input csr_op_e op,
                                            input logic [63:0] old_val,
                                            input logic [63:0] operand);
    logic [63:0] res;
    case (op)
      CSR_WRITE: res = operand;
      CSR_SET:   res = old_val | operand;
      CSR_CLEAR: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pmp_cfg_warl.sv
// Per-entry pmpcfg legalizer: turns a requested byte into the byte that is
// actually stored, honouring the entry lock and the WARL field rules.
module pmp_cfg_warl
  import pmp_pkg::*;
(
  input  pmpcfg_t    old_cfg,
  input  logic [7:0] new_byte,
  input  logic       lock,
  output pmpcfg_t    stored
);

  // Locked entries keep their byte; otherwise reserved bits read 0 and W
  // without R is dropped. All A encodings are legal at G = 0.
  always_comb begin
    stored = old_cfg;
    if (!lock) begin
      stored.locked    = new_byte[7];
      stored.reserved  = 2'b00;
      stored.addr_mode = pmp_amode_e'(new_byte[4:3]);
      stored.x         = new_byte[2];
      stored.w         = new_byte[1] & new_byte[0];
      stored.r         = new_byte[0];
    end
  end

endmodule

// File: rtl/pmp_csr_bank.sv
// Machine-mode PMP CSR bank (pmpcfg0/2, pmpaddr0..15) for RV64.
// Optional feature macro: PMP_CSR_ERR_EN -- when defined, illegal or
// unprivileged accesses are flagged on rsp_error_o; when undefined, the
// error output is tied low and illegal addresses are read-zero/write-ignore.
module pmp_csr_bank
  import pmp_pkg::*;
#(
  parameter int PMP_LEN    = 54,
  parameter int NR_ENTRIES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  input  logic [11:0]               req_addr_i,
  input  logic [1:0]                req_op_i,
  input  logic [63:0]               req_wdata_i,
  input  logic [1:0]                priv_lvl_i,
  output logic                      rsp_valid_o,
  output logic [63:0]               rsp_rdata_o,
  output logic                      rsp_error_o,
  output logic [16*PMP_LEN-1:0]     conf_addr_o,
  output logic [127:0]              conf_o,
  output logic                      cfg_changed_o
);

  pmpcfg_t [MAX_ENTRIES-1:0]               cfg_q, cfg_d;
  logic    [MAX_ENTRIES-1:0][PMP_LEN-1:0]  addr_q, addr_d;
  pmpcfg_t                                 warl_cfg [MAX_ENTRIES];
  logic    [MAX_ENTRIES-1:0]               addr_lock;

  logic        is_cfg0, is_cfg2, is_addr, addr_hit, illegal, wr_en, changed;
  logic [3:0]  idx;
  logic [63:0] old_val, new_val;

  assign is_cfg0  = (req_addr_i == CSR_PMPCFG0);
  assign is_cfg2  = (req_addr_i == CSR_PMPCFG2);
  assign is_addr  = (req_addr_i[11:4] == CSR_PMPADDR0[11:4]);
  assign idx      = req_addr_i[3:0];
  assign addr_hit = is_cfg0 | is_cfg2 | is_addr;

`ifdef PMP_CSR_ERR_EN
  assign illegal = !addr_hit || (priv_lvl_i != 2'b11);
`else
  logic unused_priv;
  assign unused_priv = ^priv_lvl_i;
  assign illegal     = !addr_hit;
`endif

  assign wr_en = req_valid_i && !illegal && (csr_op_e'(req_op_i) != CSR_READ);

  // Pre-request CSR value; illegal and unimplemented locations read 0.
  always_comb begin
    old_val = '0;
    if (!illegal) begin
      if (is_cfg0) old_val = cfg_q[7:0];
      if (is_cfg2) old_val = cfg_q[15:8];
      if (is_addr) old_val[PMP_LEN-1:0] = addr_q[idx];
    end
  end

  assign new_val = csr_apply(csr_op_e'(req_op_i), old_val, req_wdata_i);

  // One legalizer per entry; each sees its own byte of the pmpcfg word.
  // pmpaddr[i] is frozen by its own lock or a locked TOR entry above it.
  for (genvar i = 0; i < MAX_ENTRIES; i++) begin : g_entry
    pmp_cfg_warl u_warl (
      .old_cfg  (cfg_q[i]),
      .new_byte (new_val[(i%8)*8 +: 8]),
      .lock     (cfg_q[i].locked),
      .stored   (warl_cfg[i])
    );
    if (i + 1 < NR_ENTRIES) begin : g_tor
      assign addr_lock[i] = cfg_q[i].locked ||
                            (cfg_q[i+1].locked && cfg_q[i+1].addr_mode == A_TOR);
    end else begin : g_last
      assign addr_lock[i] = cfg_q[i].locked;
    end
  end

  // Next state; unimplemented entries are held at zero.
  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (i < NR_ENTRIES) begin
        if (wr_en && ((i < 8 && is_cfg0) || (i >= 8 && is_cfg2)))
          cfg_d[i] = warl_cfg[i];
        if (wr_en && is_addr && idx == 4'(i) && !addr_lock[i])
          addr_d[i] = new_val[PMP_LEN-1:0];
      end else begin
        cfg_d[i]  = '0;
        addr_d[i] = '0;
      end
    end
  end

  assign changed = (cfg_d != cfg_q) || (addr_d != addr_q);

  // State and response registers; a request during reset is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q         <= '0;
      addr_q        <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      cfg_changed_o <= 1'b0;
    end else begin
      cfg_q         <= cfg_d;
      addr_q        <= addr_d;
      rsp_valid_o   <= req_valid_i;
      cfg_changed_o <= changed;
      if (req_valid_i) rsp_rdata_o <= old_val;
    end
  end

`ifdef PMP_CSR_ERR_EN
  // Error flag travels with the response and holds between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i)            rsp_error_o <= 1'b0;
    else if (req_valid_i) rsp_error_o <= illegal;
  end
`else
  assign rsp_error_o = 1'b0;
`endif

  assign conf_o      = cfg_q;
  assign conf_addr_o = addr_q;

endmodule

// File: tb/tb_pmp_csr_bank.sv
// Randomized self-checking bench for pmp_csr_bank: a 16-entry and an
// 8-entry instance share stimulus and are each compared to a reference model.
module tb_pmp_csr_bank;

  localparam int PMP_LEN = 54;
  localparam logic [63:0] AMASK = (64'd1 << PMP_LEN) - 64'd1;
`ifdef PMP_CSR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [11:0] req_addr = '0;
  logic [1:0]  req_op = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  priv = 2'b11;

  logic [1:0]              rsp_valid, rsp_err, chg;
  logic [63:0]             rdata [2];
  logic [16*PMP_LEN-1:0]   caddr [2];
  logic [127:0]            conf  [2];

  pmp_csr_bank #(.PMP_LEN(PMP_LEN), .NR_ENTRIES(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_op_i(req_op), .req_wdata_i(wdata), .priv_lvl_i(priv),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rdata[0]), .rsp_error_o(rsp_err[0]),
    .conf_addr_o(caddr[0]), .conf_o(conf[0]), .cfg_changed_o(chg[0]));

  pmp_csr_bank #(.PMP_LEN(PMP_LEN), .NR_ENTRIES(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_op_i(req_op), .req_wdata_i(wdata), .priv_lvl_i(priv),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rdata[1]), .rsp_error_o(rsp_err[1]),
    .conf_addr_o(caddr[1]), .conf_o(conf[1]), .cfg_changed_o(chg[1]));

  // Reference model: plain byte/word arrays per instance.
  int          nr [2] = '{16, 8};
  logic [7:0]  m_cfg  [2][16];
  logic [63:0] m_addr [2][16];
  logic [63:0] e_rdata [2];
  logic        e_err [2];
  logic        e_chg [2];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_cfg[k][i]  = '0;
        m_addr[k][i] = '0;
      end
      e_rdata[k] = '0;
      e_err[k]   = 1'b0;
      e_chg[k]   = 1'b0;
    end
  endtask

  task automatic model_req(input int k, input logic [11:0] a, input logic [1:0] op,
                           input logic [63:0] wd, input logic [1:0] pv);
    logic [7:0]  oc [16];
    logic [63:0] oa [16];
    logic [63:0] old, nw;
    logic [7:0]  b, st;
    bit legal;
    int base, e, i;
    for (int j = 0; j < 16; j++) begin
      oc[j] = m_cfg[k][j];
      oa[j] = m_addr[k][j];
    end
    legal = (a == 12'h3A0) || (a == 12'h3A2) || (a >= 12'h3B0 && a <= 12'h3BF);
    if (ERR_EN && pv != 2'b11) legal = 0;
    e_err[k] = ERR_EN && !legal;
    old = '0;
    if (legal) begin
      if (a == 12'h3A0)      for (int j = 0; j < 8; j++) old[j*8 +: 8] = oc[j];
      else if (a == 12'h3A2) for (int j = 0; j < 8; j++) old[j*8 +: 8] = oc[8+j];
      else                   old = oa[int'(a) - 'h3B0];
    end
    case (op)
      2'b01:   nw = wd;
      2'b10:   nw = old | wd;
      2'b11:   nw = old & ~wd;
      default: nw = old;
    endcase
    if (legal && op != 2'b00) begin
      if (a == 12'h3A0 || a == 12'h3A2) begin
        base = (a == 12'h3A0) ? 0 : 8;
        for (int j = 0; j < 8; j++) begin
          e = base + j;
          if (e < nr[k] && !oc[e][7]) begin
            b  = nw[j*8 +: 8];
            st = b & 8'h9F;
            if (!b[0]) st[1] = 1'b0;
            m_cfg[k][e] = st;
          end
        end
      end else begin
        i = int'(a) - 'h3B0;
        if (i < nr[k] && !oc[i][7] &&
            !(i + 1 < nr[k] && oc[i+1][7] && oc[i+1][4:3] == 2'b01))
          m_addr[k][i] = nw & AMASK;
      end
    end
    e_rdata[k] = old;
    e_chg[k]   = 1'b0;
    for (int j = 0; j < 16; j++)
      if (m_cfg[k][j] != oc[j] || m_addr[k][j] != oa[j]) e_chg[k] = 1'b1;
  endtask

  task automatic check_state();
    logic [127:0] ec;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) ec[i*8 +: 8] = m_cfg[k][i];
      chk($sformatf("conf%0d", k), conf[k], ec);
      for (int i = 0; i < 16; i++)
        chk($sformatf("caddr%0d_%0d", k, i), caddr[k][i*PMP_LEN +: PMP_LEN],
            m_addr[k][i][PMP_LEN-1:0]);
    end
  endtask

  task automatic do_req(input logic [11:0] a, input logic [1:0] op,
                        input logic [63:0] wd, input logic [1:0] pv);
    req_valid = 1'b1; req_addr = a; req_op = op; wdata = wd; priv = pv;
    for (int k = 0; k < 2; k++) model_req(k, a, op, wd, pv);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rvalid%0d", k), rsp_valid[k], 1'b1);
      chk($sformatf("rdata%0d a=%0h", k, a), rdata[k], e_rdata[k]);
      chk($sformatf("err%0d", k), rsp_err[k], e_err[k]);
      chk($sformatf("chg%0d", k), chg[k], e_chg[k]);
    end
    check_state();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("idle_rvalid%0d", k), rsp_valid[k], 1'b0);
      chk($sformatf("idle_rdata_hold%0d", k), rdata[k], e_rdata[k]);
      chk($sformatf("idle_err_hold%0d", k), rsp_err[k], e_err[k]);
      chk($sformatf("idle_chg%0d", k), chg[k], 1'b0);
    end
  endtask

  task automatic do_reset(input bit with_req);
    rst = 1'b1;
    if (with_req) begin
      req_valid = 1'b1; req_addr = 12'h3A0; req_op = 2'b01;
      wdata = {$urandom, $urandom}; priv = 2'b11;
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_rvalid%0d", k), rsp_valid[k], 1'b0);
      chk($sformatf("rst_chg%0d", k), chg[k], 1'b0);
      chk($sformatf("rst_rdata%0d", k), rdata[k], 64'd0);
      chk($sformatf("rst_err%0d", k), rsp_err[k], 1'b0);
    end
    check_state();
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom % 8)
      0, 1:    return 12'h3A0;
      2:       return 12'h3A2;
      3, 4, 5: return 12'h3B0 + 12'($urandom % 16);
      6:       return ($urandom % 2) ? 12'h3A1 : 12'h3A3;
      default: return 12'($urandom % 4096);
    endcase
  endfunction

  function automatic logic [63:0] rand_wdata();
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    for (int j = 0; j < 8; j++) if ($urandom % 6 != 0) wd[j*8+7] = 1'b0;
    return wd;
  endfunction

  initial begin
    model_clear();
    do_reset(0);

    // Reads right after reset return zero.
    do_req(12'h3A0, 2'b00, 64'd0, 2'b11);
    chk("rd_cfg0_zero", rdata[0], 64'd0);
    do_req(12'h3B5, 2'b00, 64'd0, 2'b11);
    chk("rd_addr5_zero", rdata[0], 64'd0);
    chk("conf_zero", conf[0], 128'd0);

    // W without R is dropped.
    do_req(12'h3A0, 2'b01, 64'h0000_0000_0000_0F02, 2'b11);
    chk("warl_e0", conf[0][7:0], 8'h00);
    chk("warl_e1", conf[0][15:8], 8'h0F);
    chk("warl_chg", chg[0], 1'b1);
    idle();

    // Locked TOR entry above freezes pmpaddr0.
    do_reset(0);
    do_req(12'h3B0, 2'b01, 64'h1000, 2'b11);
    do_req(12'h3A0, 2'b01, 64'h0000_0000_0000_8900, 2'b11);
    do_req(12'h3B0, 2'b01, 64'h2000, 2'b11);
    chk("tor_lock_nochg", chg[0], 1'b0);
    do_req(12'h3B0, 2'b00, 64'd0, 2'b11);
    chk("tor_lock_rd", rdata[0], 64'h1000);

    // Locked byte survives a full clear.
    do_reset(0);
    do_req(12'h3A0, 2'b01, 64'h0D0D_0D0D_9F0D_0D0D, 2'b11);
    do_req(12'h3A0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
    chk("lock_clear", conf[0][63:0], 64'h0000_0000_9F00_0000);

    // Unimplemented entry on the 8-entry instance.
    do_req(12'h3BC, 2'b01, 64'hFFFF, 2'b11);
    chk("nr8_err", rsp_err[1], 1'b0);
    do_req(12'h3BC, 2'b00, 64'd0, 2'b11);
    chk("nr8_rd", rdata[1], 64'd0);
    chk("nr16_rd", rdata[0], 64'hFFFF);

`ifdef PMP_CSR_ERR_EN
    do_req(12'h3A1, 2'b00, 64'd0, 2'b11);
    chk("odd_cfg_err", rsp_err[0], 1'b1);
    chk("odd_cfg_rd", rdata[0], 64'd0);
    do_req(12'h3B0, 2'b01, 64'h55, 2'b01);
    chk("priv_err", rsp_err[0], 1'b1);
    chk("priv_nochg", chg[0], 1'b0);
`else
    do_req(12'h3A1, 2'b01, 64'hFF, 2'b11);
    chk("odd_cfg_noerr", rsp_err[0], 1'b0);
    chk("odd_cfg_rd", rdata[0], 64'd0);
`endif

    // Reset with a request in the same cycle drops it.
    do_reset(1);

    // Randomized traffic with periodic resets and idle gaps.
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 49) do_reset($urandom % 2);
      else if ($urandom % 8 == 0) idle();
      else do_req(rand_addr(), 2'($urandom % 4), rand_wdata(),
                  ($urandom % 5 == 0) ? 2'($urandom % 4) : 2'b11);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
